// File: rtl/obstacle_collision_scorer_pkg.sv
// rtl/obstacle_collision_scorer_pkg.sv - shared screen/sprite constants and game state type
package obstacle_collision_scorer_pkg;

    localparam int SCREEN_H       = 480;
    localparam int BIRD_X         = 100;
    localparam int BIRD_SIZE      = 16;
    localparam int OBSTACLE_WIDTH = 40;
    localparam int GRACE_CYCLES   = 1024;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        HIT,
        OVER
    } game_state_t;

endpackage

// File: rtl/obstacle_collision_scorer_if.sv
// rtl/obstacle_collision_scorer_if.sv - obstacle/bird sample inputs and game status outputs
interface obstacle_collision_scorer_if;

    logic        start;
    logic [8:0]  bird_y;
    logic [9:0]  x;
    logic [8:0]  yTop;
    logic [8:0]  yBot;
    logic        collision;
    logic        playing;
    logic        game_over;
    logic [11:0] score_bcd;

    modport master (
        output start, bird_y, x, yTop, yBot,
        input  collision, playing, game_over, score_bcd
    );

    modport slave (
        input  start, bird_y, x, yTop, yBot,
        output collision, playing, game_over, score_bcd
    );

endinterface

// File: rtl/obstacle_collision_scorer_bcd_score_counter.sv
// rtl/obstacle_collision_scorer_bcd_score_counter.sv - three-digit BCD counter, saturating at 999
module bcd_score_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        inc,
    output logic [11:0] value
);

    logic [11:0] value_next;

    always_comb begin
        value_next = value;
        if (value[3:0] != 4'd9) begin
            value_next[3:0] = value[3:0] + 4'd1;
        end else begin
            value_next[3:0] = 4'd0;
            if (value[7:4] != 4'd9) begin
                value_next[7:4] = value[7:4] + 4'd1;
            end else begin
                value_next[7:4]  = 4'd0;
                value_next[11:8] = value[11:8] + 4'd1;
            end
        end
    end

    // The 999 guard also keeps the hundreds digit from leaving BCD range
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            value <= 12'h000;
        end else if (inc && value != 12'h999) begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/obstacle_collision_scorer.sv
// rtl/obstacle_collision_scorer.sv - bird/pipe/ground collision, BCD scoring and game-state FSM
// Optional: define COLLISION_GRACE_EN to mask pipe hits for GRACE_CYCLES after each game start.
module obstacle_collision_scorer
    import obstacle_collision_scorer_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    obstacle_collision_scorer_if.slave   bus
);

    localparam logic [10:0] BIRD_LEFT  = 11'(BIRD_X);
    localparam logic [10:0] BIRD_RIGHT = 11'(BIRD_X + BIRD_SIZE - 1);
    localparam logic [10:0] OBST_W     = 11'(OBSTACLE_WIDTH);
    localparam logic [10:0] OBST_W_M1  = 11'(OBSTACLE_WIDTH - 1);
    localparam logic [10:0] BIRD_S_M1  = 11'(BIRD_SIZE - 1);
    localparam logic [10:0] SCREEN_ROWS = 11'(SCREEN_H);
    localparam logic [10:0] GROUND_ROW = 11'(SCREEN_H - 1);

    game_state_t state, state_next;
    logic        start_game;
    logic        scored;
    logic [9:0]  prev_x;
    logic [11:0] score;

    logic [10:0] x_w, bird_bot, bot_edge;
    logic        h_ov, top_ov, bot_ov, gnd_ov, pipe_hit, hit, grace_active;
    logic        respawn, pass, inc;

    // 11-bit widening keeps x+OBST_W and bird_y+size from wrapping
    assign x_w      = {1'b0, bus.x};
    assign bird_bot = {2'b00, bus.bird_y} + BIRD_S_M1;
    assign bot_edge = SCREEN_ROWS - {2'b00, bus.yBot};

    assign h_ov     = (x_w <= BIRD_RIGHT) && (x_w + OBST_W_M1 >= BIRD_LEFT);
    assign top_ov   = (bus.yTop != 9'd0) && (bus.bird_y < bus.yTop);
    assign bot_ov   = (bus.yBot != 9'd0) && (bird_bot >= bot_edge);
    assign gnd_ov   = bird_bot >= GROUND_ROW;
    assign pipe_hit = h_ov && (top_ov || bot_ov);
    assign hit      = (pipe_hit && !grace_active) || gnd_ov;

`ifdef COLLISION_GRACE_EN
    logic [9:0] grace_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            grace_cnt <= 10'd0;
        end else if (start_game) begin
            grace_cnt <= 10'(GRACE_CYCLES - 1);
        end else if (state == PLAY && grace_cnt != 10'd0) begin
            grace_cnt <= grace_cnt - 10'd1;
        end
    end

    assign grace_active = (grace_cnt != 10'd0);
`else
    assign grace_active = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_game = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = PLAY;
                    start_game = 1'b1;
                end
            end
            PLAY: begin
                if (hit) begin
                    state_next = HIT;
                end
            end
            HIT: begin
                state_next = OVER;
            end
            OVER: begin
                if (bus.start) begin
                    state_next = PLAY;
                    start_game = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A respawn (x jumping right) re-arms scoring and wins over a same-cycle pass
    assign respawn = bus.x > prev_x;
    assign pass    = (x_w + OBST_W) < BIRD_LEFT;
    assign inc     = (state == PLAY) && pass && !scored && !respawn;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_x <= 10'd0;
            scored <= 1'b0;
        end else begin
            prev_x <= bus.x;
            if (start_game) begin
                scored <= 1'b0;
            end else if (state == PLAY) begin
                if (respawn) begin
                    scored <= 1'b0;
                end else if (inc) begin
                    scored <= 1'b1;
                end
            end
        end
    end

    bcd_score_counter u_score (
        .clk   (clk),
        .reset (reset),
        .clear (start_game),
        .inc   (inc),
        .value (score)
    );

    assign bus.collision = (state == HIT) || (state == OVER);
    assign bus.playing   = (state == PLAY);
    assign bus.game_over = (state == OVER);
    assign bus.score_bcd = score;

endmodule

// File: tb/tb_obstacle_collision_scorer.sv
// tb/tb_obstacle_collision_scorer.sv - vector table, corner sequences and random run against a game model
module tb_obstacle_collision_scorer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    obstacle_collision_scorer_if bus ();

    obstacle_collision_scorer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef COLLISION_GRACE_EN
    localparam int GRACE_INIT = 1023;
`else
    localparam int GRACE_INIT = 0;
`endif

    int total = 0;
    int bad   = 0;

    // Reference game: phase 0 idle, 1 playing, 2 just hit, 3 over
    int m_phase, m_score, m_scored, m_prev_x, m_grace;

    function automatic bit ref_hit(int by, int x, int yt, int yb, int grace);
        bit h, top, bot, gnd;
        h   = (x <= 100 + 16 - 1) && (x + 40 - 1 >= 100);
        top = (yt > 0) && (by < yt);
        bot = (yb > 0) && (by + 16 - 1 >= 480 - yb);
        gnd = (by + 16 - 1 >= 480 - 1);
        return (h && (top || bot) && grace == 0) || gnd;
    endfunction

    function automatic void model_step(bit rst, bit st, int by, int x, int yt, int yb);
        bit hv;
        if (rst) begin
            m_phase = 0; m_score = 0; m_scored = 0; m_prev_x = 0; m_grace = 0;
            return;
        end
        hv = ref_hit(by, x, yt, yb, m_grace);
        if (m_phase == 0 || m_phase == 3) begin
            if (st) begin
                m_phase = 1; m_score = 0; m_scored = 0; m_grace = GRACE_INIT;
            end
        end else if (m_phase == 1) begin
            if (x > m_prev_x) m_scored = 0;
            else if (x + 40 < 100 && m_scored == 0) begin
                m_score  = (m_score < 999) ? m_score + 1 : 999;
                m_scored = 1;
            end
            if (m_grace > 0) m_grace--;
            if (hv) m_phase = 2;
        end else begin
            m_phase = 3;
        end
        m_prev_x = x;
    endfunction

    function automatic logic [11:0] to_bcd(int s);
        return 12'((s / 100) * 256 + ((s / 10) % 10) * 16 + (s % 10));
    endfunction

    function automatic logic [14:0] model_out();
        return {(m_phase == 2 || m_phase == 3), (m_phase == 1), (m_phase == 3), to_bcd(m_score)};
    endfunction

    function automatic logic [14:0] dut_out();
        return {bus.collision, bus.playing, bus.game_over, bus.score_bcd};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got col/play/over/score=%b/%b/%b/%h expected %b/%b/%b/%h",
                     name, act[14], act[13], act[12], act[11:0], exp[14], exp[13], exp[12], exp[11:0]);
        end
    endtask

    task automatic cycle(input bit rst, input bit st, input int by, input int x, input int yt, input int yb);
        reset      = rst;
        bus.start  = st;
        bus.bird_y = 9'(by);
        bus.x      = 10'(x);
        bus.yTop   = 9'(yt);
        bus.yBot   = 9'(yb);
        model_step(rst, st, by, x, yt, yb);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          rst;
        bit          st;
        int          by;
        int          x;
        int          yt;
        int          yb;
        logic [14:0] exp;
    } vec_t;

    function automatic vec_t mk(bit rst, bit st, int by, int x, int yt, int yb,
                                bit c, bit p, bit o, logic [11:0] s);
        vec_t r;
        r.rst = rst; r.st = st; r.by = by; r.x = x; r.yt = yt; r.yb = yb;
        r.exp = {c, p, o, s};
        return r;
    endfunction

    vec_t tbl[$];

    task automatic pass_once();
        cycle(0, 0, 200, 639, 150, 150);
        cycle(0, 0, 200, 59, 150, 150);
    endtask

    initial begin
        int rx, ryt, ryb, rby;
        bit rrst, rst_st;

        reset = 1'b1;
        bus.start = 1'b0; bus.bird_y = 9'd200; bus.x = 10'd90; bus.yTop = 9'd150; bus.yBot = 9'd150;

        //          rst st  by   x   yt   yb   col play over score
        tbl.push_back(mk(1, 0, 200,  90, 150, 150, 0, 0, 0, 12'h000));
        tbl.push_back(mk(0, 1, 200,  90, 150, 150, 0, 1, 0, 12'h000));
        tbl.push_back(mk(0, 0, 200,  90, 150, 150, 0, 1, 0, 12'h000));
        tbl.push_back(mk(0, 0, 140,  90, 150, 150, 1, 0, 0, 12'h000));
        tbl.push_back(mk(0, 0, 140,  90, 150, 150, 1, 0, 1, 12'h000));
        tbl.push_back(mk(0, 1, 200,  61, 150, 150, 0, 1, 0, 12'h000));
        tbl.push_back(mk(0, 0, 200,  61, 150, 150, 0, 1, 0, 12'h000));
        tbl.push_back(mk(0, 0, 200,  60, 150, 150, 0, 1, 0, 12'h000));
        tbl.push_back(mk(0, 0, 200,  59, 150, 150, 0, 1, 0, 12'h001));
        tbl.push_back(mk(0, 0, 200,  30, 150, 150, 0, 1, 0, 12'h001));
        tbl.push_back(mk(0, 0, 200,   0, 150, 150, 0, 1, 0, 12'h001));
        tbl.push_back(mk(0, 0, 200, 639, 150, 150, 0, 1, 0, 12'h001));
        tbl.push_back(mk(0, 0, 200,  59, 150, 150, 0, 1, 0, 12'h002));
        tbl.push_back(mk(0, 1, 200,  20, 150, 150, 0, 1, 0, 12'h002));
        tbl.push_back(mk(0, 0, 470,  20, 150, 150, 1, 0, 0, 12'h002));
        tbl.push_back(mk(1, 0, 200,  20, 150, 150, 0, 0, 0, 12'h000));
        tbl.push_back(mk(0, 1, 200, 100, 150, 150, 0, 1, 0, 12'h000));
        tbl.push_back(mk(0, 0, 150, 100, 150, 150, 0, 1, 0, 12'h000));
        tbl.push_back(mk(0, 0, 314, 100, 150, 150, 0, 1, 0, 12'h000));
        tbl.push_back(mk(0, 0, 140, 116, 150, 150, 0, 1, 0, 12'h000));
        tbl.push_back(mk(0, 0, 140,  60, 150, 150, 0, 1, 0, 12'h000));
        tbl.push_back(mk(0, 0, 320, 100, 150, 150, 1, 0, 0, 12'h000));
        tbl.push_back(mk(0, 1, 320, 100, 150, 150, 1, 0, 1, 12'h000));
        tbl.push_back(mk(0, 0, 320, 100, 150, 150, 1, 0, 1, 12'h000));
        tbl.push_back(mk(0, 1,   0, 100,   0,   0, 0, 1, 0, 12'h000));
        tbl.push_back(mk(0, 0,   0, 100,   0,   0, 0, 1, 0, 12'h000));
        tbl.push_back(mk(0, 0, 463, 100,   0,   0, 0, 1, 0, 12'h000));
        tbl.push_back(mk(0, 0, 464, 100,   0,   0, 1, 0, 0, 12'h000));

`ifndef COLLISION_GRACE_EN
        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].st, tbl[i].by, tbl[i].x, tbl[i].yt, tbl[i].yb);
            check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
        end
`else
        cycle(1, 0, 140, 90, 150, 150);
        cycle(0, 1, 140, 90, 150, 150);
        check("grace_entry", dut_out(), {3'b010, 12'h000});
        for (int k = 1; k < 1024; k++) begin
            cycle(0, 0, 140, 90, 150, 150);
            if (dut_out() !== {3'b010, 12'h000})
                check($sformatf("grace_hold%0d", k), dut_out(), {3'b010, 12'h000});
        end
        check("grace_hold_end", dut_out(), {3'b010, 12'h000});
        cycle(0, 0, 140, 90, 150, 150);
        check("grace_expire", dut_out(), {3'b100, 12'h000});
        cycle(1, 0, 470, 90, 150, 150);
        cycle(0, 1, 470, 90, 150, 150);
        check("grace_gnd_entry", dut_out(), {3'b010, 12'h000});
        cycle(0, 0, 470, 90, 150, 150);
        check("grace_gnd_hit", dut_out(), {3'b100, 12'h000});
`endif

        cycle(1, 0, 200, 90, 150, 150);
        check("reset_state", dut_out(), {3'b000, 12'h000});
        cycle(0, 1, 200, 90, 150, 150);
        for (int k = 0; k < 50; k++) begin
            cycle(0, 0, 200, 90, 150, 150);
            check("gap_clear", dut_out(), {3'b010, 12'h000});
        end

        cycle(1, 0, 200, 639, 150, 150);
        cycle(0, 1, 200, 639, 150, 150);
        for (int k = 0; k < 99; k++) pass_once();
        check("score_099", dut_out(), {3'b010, 12'h099});
        pass_once();
        check("score_100", dut_out(), {3'b010, 12'h100});
        for (int k = 0; k < 899; k++) pass_once();
        check("score_999", dut_out(), {3'b010, 12'h999});
        pass_once();
        check("score_sat", dut_out(), {3'b010, 12'h999});

        rx = 639; ryt = 150; ryb = 150; rby = 200;
        cycle(1, 0, rby, rx, ryt, ryb);
        check("rand_reset", dut_out(), model_out());
        for (int i = 0; i < 4000; i++) begin
            rrst   = ($urandom_range(0, 299) == 0);
            rst_st = ($urandom_range(0, 11) == 0);
            rx = rx - int'($urandom_range(0, 4));
            if (rx < 0) begin
                rx  = 639;
                ryt = $urandom_range(0, 200);
                ryb = $urandom_range(0, 200);
                rby = ryt + $urandom_range(0, 480 - ryt - ryb - 16);
            end
            if ($urandom_range(0, 49) == 0) rby = $urandom_range(0, 511);
            cycle(rrst, rst_st, rby, rx, ryt, ryb);
            check($sformatf("random%0d", i), dut_out(), model_out());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
